udp_payload_inserter_nstage_pipeline: RTL and testbench
=======================================================

// Module: udp_payload_inserter_nstage_pipeline
// PURPOSE
//  - Parametrised DEPTH-entry elastic buffer for the UDP TX offload path, used between
//    payload inserter sub-blocks.
//  - Replaces the single-buffered stage with:
//    - full 1 beat/clk throughput;
//    - an in_ready that has no combinational path from out_ready;
//    - optional fill-level reporting.
//  - Valid/ready streaming on both sides; data is transferred when valid && ready.
// PARAMETERS
//  - PAYLOAD_WIDTH  8    width of in_payload/out_payload in bits
//  - DEPTH          4    number of storage entries; power of 2, >= 2
//  - ALMOST_FULL    3    level threshold for almost_full; 1..DEPTH; used only with UDP_PIPE_LEVEL_EN
//  - LW                  localparam = $clog2(DEPTH+1), width of level
// PORTS
//  - clk          in   1              clock, all logic on rising edge
//  - reset_n      in   1              asynchronous, active-low reset
//  - in_valid     in   1              upstream beat valid
//  - in_payload   in   PAYLOAD_WIDTH  upstream beat data
//  - in_ready     out  1              buffer can accept a beat this cycle
//  - out_valid    out  1              downstream beat valid
//  - out_payload  out  PAYLOAD_WIDTH  downstream beat data
//  - out_ready    in   1              downstream accepts a beat this cycle
//  - level        out  LW             entries held (UDP_PIPE_LEVEL_EN only)
//  - almost_full  out  1              level >= ALMOST_FULL (UDP_PIPE_LEVEL_EN only)
// BEHAVIOUR
//  - Reset: clk is the clock; reset_n is an asynchronous, active-low reset.
//    - While reset_n = 0: count, wr_ptr and rd_ptr are 0.
//    - Outputs while reset_n = 0: out_valid = 0, out_payload = 0, in_ready = 0, level = 0,
//      almost_full = 0.
//    - Storage array is not reset.
//    - in_ready goes to 1 on the first rising clk edge after reset_n deasserts.
//  - State: circular buffer mem[DEPTH], wr_ptr/rd_ptr ($clog2(DEPTH) bits), count (LW bits).
//    - Pointers wrap modulo DEPTH; DEPTH is a power of 2, so wrap is natural overflow.
//  - in_ready is a registered flag: 1 iff the count after the current edge is < DEPTH.
//    It never depends on out_ready in the same cycle.
//  - out_valid = (count != 0).
//  - out_payload = mem[rd_ptr] when out_valid = 1, else 0. No X is ever presented.
//  - push = in_valid & in_ready: write mem[wr_ptr], then wr_ptr++.
//  - pop = out_valid & out_ready: rd_ptr++.
//  - count update: push & ~pop -> +1; pop & ~push -> -1; push & pop -> unchanged.
//  - Latency: a beat pushed into an empty buffer is presented on out_* 1 clk later.
//    There is no same-cycle pass-through.
//  - Full (count = DEPTH): in_ready = 0 even if out_ready = 1 in that cycle.
//    - A pop frees a slot; in_ready returns to 1 on the next cycle.
//    - in_valid while full is held off by upstream; no beat is lost or overwritten.
//  - Empty (count = 0): out_valid = 0 and out_ready is ignored; no underflow and no pointer move.
//  - Simultaneous push & pop with 0 < count < DEPTH: both occur and count is unchanged.
//    Sustained rate is 1 beat/clk.
//  - Order: beats are delivered strictly in FIFO order; the data sequence is identical
//    in and out.
//  - Reset mid-operation: all held beats are discarded; the buffer restarts empty.
//  - out_valid/out_payload stay stable while out_valid = 1 and out_ready = 0.
// CONFIGURATION
//  - UDP_PIPE_LEVEL_EN defined:
//    - Ports level and almost_full exist.
//    - level = count, registered.
//    - almost_full = (count >= ALMOST_FULL), registered in the same edge as count.
//  - UDP_PIPE_LEVEL_EN undefined:
//    - Ports level and almost_full are absent; ALMOST_FULL is unused.
//    - Datapath behaviour is identical to the defined case.
// TESTING
//  - Reset: hold reset_n = 0 with in_valid = 1.
//    -> out_valid = 0, out_payload = 0, in_ready = 0, level = 0.
//    -> in_ready = 1 one clk after release.
//  - Fill: DEPTH = 4, out_ready = 0, push 0x11, 0x22, 0x33, 0x44.
//    -> in_ready = 0 after the 4th push; level = 4; almost_full = 1 from level 3.
//    -> a 5th beat 0x55 is not accepted.
//  - Full + pop: from full, out_ready = 1 for 1 clk with in_valid = 1.
//    -> 0x11 popped, no push that cycle.
//    -> in_ready = 1 next clk, then 0x55 accepted; level returns to 4.
//  - Streaming: in_valid = 1 and out_ready = 1 continuously for 256 beats of an
//    incrementing pattern from empty.
//    -> first out_valid 1 clk after the first push; then 1 beat/clk.
//    -> output sequence 0x00..0xFF in order; level <= 1 throughout.
//  - Random backpressure: random in_valid/out_ready at 50% each, 10k beats, DEPTH = 8.
//    -> scoreboard matches in order; out_payload stable while stalled.
//    -> level never > 8; no push when full, no pop when empty.
//  - Mid-operation reset: assert reset_n = 0 at level 3.
//    -> out_valid = 0 immediately (async).
//    -> after release, the first output is the first beat pushed post-reset.

Source files
------------

// File: rtl/udp_payload_inserter_nstage_pipeline_if.sv
// Valid/ready bus for the payload inserter elastic buffer.
// Carries both the upstream (in_*) and downstream (out_*) handshakes.
// slave  : view taken by the buffer itself.
// master : view taken by whatever drives and consumes the buffer.
interface udp_payload_inserter_nstage_pipeline_if #(
    parameter int PAYLOAD_WIDTH = 8
);
    logic                     in_valid;
    logic [PAYLOAD_WIDTH-1:0] in_payload;
    logic                     in_ready;
    logic                     out_valid;
    logic [PAYLOAD_WIDTH-1:0] out_payload;
    logic                     out_ready;

    modport slave (
        input  in_valid, in_payload, out_ready,
        output in_ready, out_valid, out_payload
    );

    modport master (
        output in_valid, in_payload, out_ready,
        input  in_ready, out_valid, out_payload
    );
endinterface

// File: rtl/udp_payload_inserter_nstage_pipeline.sv
// DEPTH-entry elastic buffer for the UDP TX payload inserter path.
// Full 1 beat/clk throughput; in_ready is registered so it never sees out_ready
// combinationally. Defining UDP_PIPE_LEVEL_EN adds the level / almost_full ports.
module udp_payload_inserter_nstage_pipeline #(
    parameter  int PAYLOAD_WIDTH = 8,
    parameter  int DEPTH         = 4,
    parameter  int ALMOST_FULL   = 3,
    localparam int LW            = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic reset_n,
    udp_payload_inserter_nstage_pipeline_if.slave io_bus
`ifdef UDP_PIPE_LEVEL_EN
    ,
    output logic [LW-1:0] level,
    output logic          almost_full
`endif
);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [PAYLOAD_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [LW-1:0]            r_count;
    logic                     r_in_ready;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_out_valid;
    logic [LW-1:0]            w_count_nxt;

    assign w_out_valid = (r_count != '0);
    assign w_push      = io_bus.in_valid & r_in_ready;
    assign w_pop       = w_out_valid & io_bus.out_ready;

    assign io_bus.in_ready    = r_in_ready;
    assign io_bus.out_valid   = w_out_valid;
    // Zero rather than stale/unreset storage when nothing is held.
    assign io_bus.out_payload = w_out_valid ? r_mem[r_rd_ptr] : '0;

    // Occupancy after the coming edge; also feeds the registered ready flag.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + LW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - LW'(1);
        end
    end

    // Pointers, occupancy and the registered accept flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < DEPTH_L);
        end
    end

    // Storage write; the array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_bus.in_payload;
        end
    end

`ifdef UDP_PIPE_LEVEL_EN
    localparam logic [LW-1:0] AF_L = LW'(ALMOST_FULL);

    logic r_almost_full;

    // Threshold flag updated on the same edge as the count it describes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_nxt >= AF_L);
        end
    end

    assign level       = r_count;
    assign almost_full = r_almost_full;
`endif
endmodule

// File: tb/tb_udp_payload_inserter_nstage_pipeline.sv
// Directed + random-backpressure bench for udp_payload_inserter_nstage_pipeline.
// DUT a: DEPTH=4 (reset, fill, full+pop, streaming, mid-op reset).
// DUT b: DEPTH=8 (random valid/ready, 10k beats).
module tb_udp_payload_inserter_nstage_pipeline;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    udp_payload_inserter_nstage_pipeline_if #(.PAYLOAD_WIDTH(W)) a_bus ();
    udp_payload_inserter_nstage_pipeline_if #(.PAYLOAD_WIDTH(W)) b_bus ();

`ifdef UDP_PIPE_LEVEL_EN
    logic [2:0] a_level;
    logic       a_af;
    logic [3:0] b_level;
    logic       b_af;
`endif

    udp_payload_inserter_nstage_pipeline #(
        .PAYLOAD_WIDTH(W), .DEPTH(4), .ALMOST_FULL(3)
    ) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (a_bus)
`ifdef UDP_PIPE_LEVEL_EN
        ,
        .level       (a_level),
        .almost_full (a_af)
`endif
    );

    udp_payload_inserter_nstage_pipeline #(
        .PAYLOAD_WIDTH(W), .DEPTH(8), .ALMOST_FULL(6)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (b_bus)
`ifdef UDP_PIPE_LEVEL_EN
        ,
        .level       (b_level),
        .almost_full (b_af)
`endif
    );

    int n_err = 0;
    int n_chk = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    bit           ra = 1'b0;
    bit           rb = 1'b0;
    int           n_out_b = 0;
    int           n_in_b  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock on DUT a: drive, check against model, step model at the edge.
    task automatic cyc_a(input bit v, input logic [W-1:0] d, input bit r);
        bit push, pop;
        a_bus.in_valid   = v;
        a_bus.in_payload = d;
        a_bus.out_ready  = r;
        #3;
        check("a_in_ready", {31'd0, a_bus.in_ready}, {31'd0, ra});
        check("a_out_valid", {31'd0, a_bus.out_valid}, {31'd0, qa.size() != 0});
        check("a_out_payload", {24'd0, a_bus.out_payload}, (qa.size() != 0) ? {24'd0, qa[0]} : 32'd0);
`ifdef UDP_PIPE_LEVEL_EN
        check("a_level", {29'd0, a_level}, qa.size());
        check("a_almost_full", {31'd0, a_af}, {31'd0, qa.size() >= 3});
`endif
        @(posedge clk);
        if (!reset_n) begin
            qa.delete();
            ra = 1'b0;
        end else begin
            push = v && ra;
            pop  = r && (qa.size() != 0);
            if (pop)  void'(qa.pop_front());
            if (push) qa.push_back(d);
            ra = (qa.size() < 4);
        end
        #1;
    endtask

    task automatic cyc_b(input bit v, input logic [W-1:0] d, input bit r);
        bit push, pop;
        b_bus.in_valid   = v;
        b_bus.in_payload = d;
        b_bus.out_ready  = r;
        #3;
        check("b_in_ready", {31'd0, b_bus.in_ready}, {31'd0, rb});
        check("b_out_valid", {31'd0, b_bus.out_valid}, {31'd0, qb.size() != 0});
        check("b_out_payload", {24'd0, b_bus.out_payload}, (qb.size() != 0) ? {24'd0, qb[0]} : 32'd0);
`ifdef UDP_PIPE_LEVEL_EN
        check("b_level", {28'd0, b_level}, qb.size());
        check("b_almost_full", {31'd0, b_af}, {31'd0, qb.size() >= 6});
`endif
        @(posedge clk);
        push = v && rb;
        pop  = r && (qb.size() != 0);
        if (pop) begin
            void'(qb.pop_front());
            n_out_b++;
        end
        if (push) begin
            qb.push_back(d);
            n_in_b++;
        end
        rb = (qb.size() < 8);
        #1;
    endtask

    initial begin
        a_bus.in_valid = 1'b1; a_bus.in_payload = 8'hEE; a_bus.out_ready = 1'b0;
        b_bus.in_valid = 1'b0; b_bus.in_payload = '0;    b_bus.out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset held with in_valid high.
        repeat (3) cyc_a(1'b1, 8'hEE, 1'b1);
        a_bus.in_valid = 1'b0;
        reset_n = 1'b1;
        cyc_a(1'b0, 8'h00, 1'b0);
        check("a_ready_after_release", {31'd0, a_bus.in_ready}, 32'd1);

        // Fill to DEPTH, 5th beat refused.
        cyc_a(1'b1, 8'h11, 1'b0);
        cyc_a(1'b1, 8'h22, 1'b0);
        cyc_a(1'b1, 8'h33, 1'b0);
        cyc_a(1'b1, 8'h44, 1'b0);
        cyc_a(1'b1, 8'h55, 1'b0);
        check("a_full_ready_low", {31'd0, a_bus.in_ready}, 32'd0);
        check("a_full_head", {24'd0, a_bus.out_payload}, 32'h11);

        // Full + single pop: no push that cycle, 0x55 taken next cycle.
        cyc_a(1'b1, 8'h55, 1'b1);
        check("a_after_pop_head", {24'd0, a_bus.out_payload}, 32'h22);
        cyc_a(1'b1, 8'h55, 1'b0);
        cyc_a(1'b0, 8'h00, 1'b0);
        check("a_refull_ready_low", {31'd0, a_bus.in_ready}, 32'd0);

        // Drain: 22 33 44 55.
        repeat (5) cyc_a(1'b0, 8'h00, 1'b1);
        check("a_drained_empty", {31'd0, a_bus.out_valid}, 32'd0);

        // Streaming 256 beats, out_ready held high.
        for (int i = 0; i < 256; i++) cyc_a(1'b1, i[7:0], 1'b1);
        repeat (2) cyc_a(1'b0, 8'h00, 1'b1);

        // Mid-operation reset at level 3.
        cyc_a(1'b1, 8'hA1, 1'b0);
        cyc_a(1'b1, 8'hA2, 1'b0);
        cyc_a(1'b1, 8'hA3, 1'b0);
        check("a_pre_reset_valid", {31'd0, a_bus.out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("a_async_out_valid", {31'd0, a_bus.out_valid}, 32'd0);
        check("a_async_out_payload", {24'd0, a_bus.out_payload}, 32'd0);
        check("a_async_in_ready", {31'd0, a_bus.in_ready}, 32'd0);
        qa.delete();
        ra = 1'b0;
        cyc_a(1'b1, 8'hEE, 1'b0);
        reset_n = 1'b1;
        cyc_a(1'b0, 8'h00, 1'b0);
        cyc_a(1'b1, 8'h5A, 1'b0);
        check("a_post_reset_first", {24'd0, a_bus.out_payload}, 32'h5A);
        cyc_a(1'b0, 8'h00, 1'b1);
        cyc_a(1'b0, 8'h00, 1'b0);

        // Random backpressure on DEPTH=8, 10k beats.
        rb = 1'b1;
        for (int c = 0; c < 60000 && n_out_b < 10000; c++) begin
            bit v, r;
            v = ($urandom_range(1) == 1) && (n_in_b < 10000);
            r = ($urandom_range(1) == 1);
            cyc_b(v, 8'($urandom), r);
        end
        check("b_all_beats_out", n_out_b, 32'd10000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
